// File: rtl/video_pkg.sv
// Shared video datapath definitions: scaled frame geometry, RLE token
// field positions and the frame writer state encoding.
package video_pkg;

  localparam int X_RES_SCALED   = 160;
  localparam int Y_RES_SCALED   = 120;
  localparam int X_ADDRW_SCALED = 8;
  localparam int Y_ADDRW_SCALED = 7;

  localparam int TOK_COLOUR_BIT = 7;
  localparam int TOK_RUN_MSB    = 6;

  typedef enum logic [0:0] {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } writer_state_t;

  // Run field stores length minus one, so 0..127 maps to 1..128 pixels.
  function automatic logic [7:0] tok_run_len(input logic [7:0] tok);
    return {1'b0, tok[TOK_RUN_MSB:0]} + 8'd1;
  endfunction

endpackage

// File: rtl/frame_writer_if.sv
// Token stream and frame-memory write port of the frame writer.
// master: the writer itself; slave: token source / frame memory side.
interface frame_writer_if #(
  parameter int X_ADDRW = video_pkg::X_ADDRW_SCALED,
  parameter int Y_ADDRW = video_pkg::Y_ADDRW_SCALED
);

  logic               tok_valid;
  logic [7:0]         tok_data;
  logic               tok_ready;
  logic [X_ADDRW-1:0] mem_x_pos;
  logic [Y_ADDRW-1:0] mem_y_pos;
  logic               pixel_data;
  logic               write_enable;

  modport master (
    input  tok_valid, tok_data,
    output tok_ready, mem_x_pos, mem_y_pos, pixel_data, write_enable
  );

  modport slave (
    output tok_valid, tok_data,
    input  tok_ready, mem_x_pos, mem_y_pos, pixel_data, write_enable
  );

endinterface

// File: rtl/frame_pos_counter.sv
// Raster position counter with line and frame wrap plus a last-pixel flag;
// usable for both the writer and the VGA scan position.
module frame_pos_counter #(
  parameter int X_RES = video_pkg::X_RES_SCALED,
  parameter int Y_RES = video_pkg::Y_RES_SCALED,
  parameter int X_W   = video_pkg::X_ADDRW_SCALED,
  parameter int Y_W   = video_pkg::Y_ADDRW_SCALED
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           adv,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic x_end;
  logic y_end;

  assign x_end = (x == X_W'(X_RES - 1));
  assign y_end = (y == Y_W'(Y_RES - 1));
  assign last  = x_end && y_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_writer.sv
// Expands RLE monochrome tokens into one pixel write per cycle and owns the
// bank-select flag. Define FRAME_WRITER_TEARFREE_EN to defer swaps to vsync.
//
// state     | meaning
// FILL      | expanding tokens into pixel writes for the current frame
// WAIT_SWAP | frame complete, holding off tokens until vsync_start swaps
module frame_writer #(
  parameter int X_RES_SCALED   = video_pkg::X_RES_SCALED,
  parameter int Y_RES_SCALED   = video_pkg::Y_RES_SCALED,
  parameter int X_ADDRW_SCALED = video_pkg::X_ADDRW_SCALED,
  parameter int Y_ADDRW_SCALED = video_pkg::Y_ADDRW_SCALED
) (
  input  logic           clk,
  input  logic           rst_n,
  frame_writer_if.master bus,
  input  logic           vsync_start,
  output logic           video_bank_sel,
  output logic           frame_swapped,
  output logic           overrun
);

  import video_pkg::*;

  writer_state_t state_q, state_d;
  logic [7:0]    run_cnt_q, run_cnt_d;
  logic          run_colour_q, run_colour_d;
  logic          ready_en_q;
  logic          ready, accept, emit, swap, ovr_set;
  logic          last_pix;

  logic [X_ADDRW_SCALED-1:0] x_cnt, x_q;
  logic [Y_ADDRW_SCALED-1:0] y_cnt, y_q;
  logic                      pix_q, we_q, bank_q, swapped_q, overrun_q;

  frame_pos_counter #(
    .X_RES (X_RES_SCALED),
    .Y_RES (Y_RES_SCALED),
    .X_W   (X_ADDRW_SCALED),
    .Y_W   (Y_ADDRW_SCALED)
  ) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (emit),
    .x     (x_cnt),
    .y     (y_cnt),
    .last  (last_pix)
  );

  // ready_en keeps tok_ready low while in reset and for the release cycle.
  assign ready         = ready_en_q && (state_q == FILL) && (run_cnt_q <= 8'd1);
  assign accept        = bus.tok_valid && ready;
  assign bus.tok_ready = ready;

`ifndef FRAME_WRITER_TEARFREE_EN
  logic unused_vsync;
  assign unused_vsync = vsync_start;
`endif

  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    run_colour_d = run_colour_q;
    emit         = 1'b0;
    swap         = 1'b0;
    ovr_set      = 1'b0;
    case (state_q)
      FILL: begin
        if (run_cnt_q != 8'd0) begin
          emit      = 1'b1;
          run_cnt_d = run_cnt_q - 8'd1;
          if (last_pix) begin
            ovr_set   = (run_cnt_q > 8'd1);
            run_cnt_d = 8'd0;
`ifdef FRAME_WRITER_TEARFREE_EN
            state_d   = WAIT_SWAP;
`else
            swap      = 1'b1;
`endif
          end
        end
      end
      WAIT_SWAP: begin
`ifdef FRAME_WRITER_TEARFREE_EN
        if (vsync_start) begin
          state_d = FILL;
          swap    = 1'b1;
        end
`else
        state_d = FILL;
`endif
      end
      default: state_d = FILL;
    endcase
    // A token taken on the final pixel of a run belongs to the next run
    // (or the next frame when that pixel also ends the frame).
    if (accept) begin
      run_cnt_d    = tok_run_len(bus.tok_data);
      run_colour_d = bus.tok_data[TOK_COLOUR_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      run_cnt_q    <= 8'd0;
      run_colour_q <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      run_colour_q <= run_colour_d;
      ready_en_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      pix_q     <= 1'b0;
      bank_q    <= 1'b0;
      swapped_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      we_q      <= emit;
      swapped_q <= swap;
      bank_q    <= bank_q ^ swap;
      overrun_q <= overrun_q | ovr_set;
      if (emit) begin
        x_q   <= x_cnt;
        y_q   <= y_cnt;
        pix_q <= run_colour_q;
      end
    end
  end

  assign bus.write_enable = we_q;
  assign bus.mem_x_pos    = x_q;
  assign bus.mem_y_pos    = y_q;
  assign bus.pixel_data   = pix_q;
  assign video_bank_sel   = bank_q;
  assign frame_swapped    = swapped_q;
  assign overrun          = overrun_q;

endmodule
